// File: rtl/text_row_fetcher.sv
// Prefetches one text row of charattr words per display row into a ping-pong
// buffer via SDRAM bursts, and tracks the scanline/row position of the raster.
module text_row_fetcher #(
    parameter int COLUMNS     = 80,
    parameter int ROWS        = 51,
    parameter int CHAR_HEIGHT = 20,
    parameter int ADDR_WIDTH  = 23,
    parameter int DATA_WIDTH  = 32,
    parameter int PAGE_SIZE   = COLUMNS * ROWS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_start,
    input  logic                           line_start,
    input  logic [ADDR_WIDTH-1:0]          base_address,
    input  logic [ADDR_WIDTH-1:0]          first_row,
    input  logic [$clog2(CHAR_HEIGHT)-1:0] scroll,
    output logic                           rd_request,
    output logic [ADDR_WIDTH-1:0]          rd_address,
    output logic [8:0]                     rd_burst_length,
    input  logic                           rd_ack,
    input  logic                           rd_available,
    input  logic [DATA_WIDTH-1:0]          rd_data,
    input  logic [$clog2(COLUMNS)-1:0]     col_index,
    output logic [DATA_WIDTH-1:0]          charattr,
    output logic [$clog2(CHAR_HEIGHT)-1:0] char_row,
    output logic [$clog2(ROWS+1)-1:0]      text_row,
    output logic                           row_valid,
    output logic                           underrun
);

    localparam int HW = $clog2(CHAR_HEIGHT);
    localparam int CW = $clog2(COLUMNS);
    localparam int RW = $clog2(ROWS + 1);
    localparam int NW = $clog2(COLUMNS + 1);

    localparam logic [31:0] COLUMNS_U = 32'(COLUMNS);
    localparam logic [31:0] ROWS_U    = 32'(ROWS);
    localparam logic [31:0] HEIGHT_U  = 32'(CHAR_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] COL_STEP  = ADDR_WIDTH'(COLUMNS);
    localparam logic [ADDR_WIDTH-1:0] PAGE_STEP = ADDR_WIDTH'(PAGE_SIZE);

    typedef enum logic [1:0] {IDLE, REQUEST, RECEIVE} fetch_state_t;

    fetch_state_t              state_q, state_d;
    logic                      rd_request_q, rd_request_d;
    logic [ADDR_WIDTH-1:0]     rd_address_q, rd_address_d;
    logic [ADDR_WIDTH-1:0]     fetch_addr_q, fetch_addr_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [HW-1:0]             scroll_q, scroll_d;
    logic [RW-1:0]             text_row_q, text_row_d;
    logic [HW-1:0]             char_row_q, char_row_d;
    logic                      row_valid_q, row_valid_d;
    logic                      first_line_q, first_line_d;
    logic                      fill_sel_q, fill_sel_d;
    logic                      underrun_q, underrun_d;
    logic [NW-1:0]             word_cnt_q, word_cnt_d;
    logic [DATA_WIDTH-1:0]     charattr_q, charattr_d;

    logic                      buf_we;
    logic                      start_fetch;
    logic                      swap;
    logic [ADDR_WIDTH-1:0]     start_addr;
    logic [ADDR_WIDTH-1:0]     page_base;
    logic [ADDR_WIDTH-1:0]     step_addr;
    logic [ADDR_WIDTH-1:0]     page_end;
    logic [31:0]               next_row;
    logic [31:0]               rows_shown;

    logic [DATA_WIDTH-1:0]     line_buf [2][COLUMNS];

    assign rd_request      = rd_request_q;
    assign rd_address      = rd_address_q;
    assign rd_burst_length = 9'(COLUMNS);
    assign charattr        = charattr_q;
    assign char_row        = char_row_q;
    assign text_row        = text_row_q;
    assign row_valid       = row_valid_q;
    assign underrun        = underrun_q;

    always_comb begin
        state_d      = state_q;
        rd_request_d = rd_request_q;
        rd_address_d = rd_address_q;
        fetch_addr_d = fetch_addr_q;
        base_d       = base_q;
        scroll_d     = scroll_q;
        text_row_d   = text_row_q;
        char_row_d   = char_row_q;
        row_valid_d  = row_valid_q;
        first_line_d = first_line_q;
        fill_sel_d   = fill_sel_q;
        underrun_d   = underrun_q;
        word_cnt_d   = word_cnt_q;
        buf_we       = 1'b0;
        start_fetch  = 1'b0;
        swap         = 1'b0;
        start_addr   = fetch_addr_q;
        page_base    = base_q;
        next_row     = 32'(text_row_q) + 32'd1;
        rows_shown   = (scroll_q != '0) ? ROWS_U + 32'd1 : ROWS_U;

        case (state_q)
            REQUEST: begin
                if (rd_ack) begin
                    state_d      = RECEIVE;
                    rd_request_d = 1'b0;
                end
            end
            RECEIVE: begin
                if (rd_available) begin
                    buf_we     = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (32'(word_cnt_q) == COLUMNS_U - 32'd1) state_d = IDLE;
                end
            end
            default: ;
        endcase

        // The fetch started on entering row r prefetches row r+1, so the last
        // displayed row triggers a swap but no new burst.
        if (frame_start) begin
            base_d       = base_address;
            scroll_d     = scroll;
            text_row_d   = '0;
            char_row_d   = scroll;
            row_valid_d  = 1'b0;
            first_line_d = 1'b1;
            fill_sel_d   = 1'b0;
            start_fetch  = 1'b1;
            start_addr   = first_row;
            page_base    = base_address;
        end else if (line_start && first_line_q) begin
            first_line_d = 1'b0;
            row_valid_d  = 1'b1;
            swap         = 1'b1;
            start_fetch  = 1'b1;
        end else if (line_start && row_valid_q) begin
            if (32'(char_row_q) == HEIGHT_U - 32'd1) begin
                char_row_d = '0;
                if (next_row >= rows_shown) begin
                    row_valid_d = 1'b0;
                end else begin
                    text_row_d  = next_row[RW-1:0];
                    swap        = 1'b1;
                    start_fetch = (next_row + 32'd1) < rows_shown;
                end
            end else begin
                char_row_d = char_row_q + 1'b1;
            end
        end

        if (swap) begin
            fill_sel_d = ~fill_sel_q;
            if (state_q != IDLE) begin
                underrun_d   = 1'b1;
                state_d      = IDLE;
                rd_request_d = 1'b0;
                buf_we       = 1'b0;
            end
        end

        step_addr = start_addr + COL_STEP;
        page_end  = page_base + PAGE_STEP;
        if (start_fetch) begin
            state_d      = REQUEST;
            rd_request_d = 1'b1;
            rd_address_d = start_addr;
            word_cnt_d   = '0;
            buf_we       = 1'b0;
            fetch_addr_d = (step_addr >= page_end) ? page_base : step_addr;
        end

        charattr_d = (32'(col_index) < COLUMNS_U) ? line_buf[~fill_sel_q][col_index] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rd_request_q <= 1'b0;
            rd_address_q <= '0;
            fetch_addr_q <= '0;
            base_q       <= '0;
            scroll_q     <= '0;
            text_row_q   <= '0;
            char_row_q   <= '0;
            row_valid_q  <= 1'b0;
            first_line_q <= 1'b0;
            fill_sel_q   <= 1'b0;
            underrun_q   <= 1'b0;
            word_cnt_q   <= '0;
            charattr_q   <= '0;
        end else begin
            state_q      <= state_d;
            rd_request_q <= rd_request_d;
            rd_address_q <= rd_address_d;
            fetch_addr_q <= fetch_addr_d;
            base_q       <= base_d;
            scroll_q     <= scroll_d;
            text_row_q   <= text_row_d;
            char_row_q   <= char_row_d;
            row_valid_q  <= row_valid_d;
            first_line_q <= first_line_d;
            fill_sel_q   <= fill_sel_d;
            underrun_q   <= underrun_d;
            word_cnt_q   <= word_cnt_d;
            charattr_q   <= charattr_d;
        end
    end

    // Buffer storage is never cleared, so aborted bursts leave stale words behind.
    always_ff @(posedge clk) begin
        if (buf_we && !reset) line_buf[fill_sel_q][word_cnt_q[CW-1:0]] <= rd_data;
    end

endmodule

// File: tb/tb_text_row_fetcher.sv
// Self-checking bench for text_row_fetcher: a scripted SDRAM responder plus a
// frame-level reference model (row/scanline arithmetic and page-wrapped addresses).
module tb_text_row_fetcher;

    localparam int COLUMNS = 4;
    localparam int ROWS    = 3;
    localparam int CH      = 2;
    localparam int PAGE    = 12;
    localparam int AW      = 23;
    localparam int DW      = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic          line_start;
    logic [AW-1:0] base_address;
    logic [AW-1:0] first_row;
    logic [0:0]    scroll;
    logic          rd_request;
    logic [AW-1:0] rd_address;
    logic [8:0]    rd_burst_length;
    logic          rd_ack;
    logic          rd_available;
    logic [DW-1:0] rd_data;
    logic [1:0]    col_index;
    logic [DW-1:0] charattr;
    logic [0:0]    char_row;
    logic [1:0]    text_row;
    logic          row_valid;
    logic          underrun;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] salt;

    text_row_fetcher #(
        .COLUMNS(COLUMNS), .ROWS(ROWS), .CHAR_HEIGHT(CH),
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PAGE_SIZE(PAGE)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .line_start(line_start),
        .base_address(base_address), .first_row(first_row), .scroll(scroll),
        .rd_request(rd_request), .rd_address(rd_address), .rd_burst_length(rd_burst_length),
        .rd_ack(rd_ack), .rd_available(rd_available), .rd_data(rd_data),
        .col_index(col_index), .charattr(charattr), .char_row(char_row),
        .text_row(text_row), .row_valid(row_valid), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input int addr, input int i);
        return (32'(addr) << 8) ^ 32'(i) ^ salt;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        frame_start = 1'b0; line_start = 1'b0; rd_ack = 1'b0;
        rd_available = 1'b0; col_index = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic pulse_frame(input int b, input int f, input logic s);
        base_address = AW'(b); first_row = AW'(f); scroll = s;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
    endtask

    task automatic pulse_line();
        line_start = 1'b1; tick(); line_start = 1'b0;
    endtask

    // Plays the SDRAM side of one burst; reports whether a request appeared,
    // its address, and whether the request stayed stable and dropped after ack.
    task automatic serve_burst(input int n_words, input int ack_delay,
                               output logic seen, output int addr, output logic stable);
        seen = 1'b0; stable = 1'b1; addr = 0;
        for (int t = 0; t < 64 && rd_request !== 1'b1; t++) tick();
        if (rd_request !== 1'b1) return;
        seen = 1'b1;
        addr = int'(rd_address);
        if (rd_burst_length !== 9'd4) stable = 1'b0;
        for (int d = 0; d < ack_delay; d++) begin
            tick();
            if (rd_request !== 1'b1 || int'(rd_address) != addr || rd_burst_length !== 9'd4)
                stable = 1'b0;
        end
        rd_ack = 1'b1; tick(); rd_ack = 1'b0;
        if (rd_request !== 1'b0) stable = 1'b0;
        for (int i = 0; i < n_words; i++) begin
            if ($urandom_range(0, 2) == 0) begin rd_data = $urandom; tick(); end
            rd_available = 1'b1; rd_data = word_of(addr, i); tick();
            rd_available = 1'b0; rd_data = $urandom;
        end
    endtask

    task automatic test_reset();
        do_reset();
        pulse_frame(40, 52, 1'b1);
        pulse_line();
        do_reset();
        checks++;
        if (rd_request !== 1'b0 || rd_address !== '0 || rd_burst_length !== 9'd4 ||
            row_valid !== 1'b0 || underrun !== 1'b0 || text_row !== 2'd0 ||
            char_row !== 1'b0 || charattr !== '0)
            begin failures++; $display("[TB] FAIL reset_state: req=%0b addr=%0d len=%0d valid=%0b under=%0b trow=%0d crow=%0d ca=%h required 0,0,4,0,0,0,0,0",
                     rd_request, rd_address, rd_burst_length, row_valid, underrun, text_row, char_row, charattr); end
        pulse_line();
        tick();
        checks++;
        if (rd_request !== 1'b0 || row_valid !== 1'b0)
            begin failures++; $display("[TB] FAIL line_without_frame: req=%0b valid=%0b required 0,0", rd_request, row_valid); end
    endtask

    task automatic test_basic_fetch();
        logic seen, stable; int got;
        do_reset();
        pulse_frame(100, 100, 1'b0);
        checks++;
        if (rd_request !== 1'b1 || rd_address !== 23'd100 || rd_burst_length !== 9'd4)
            begin failures++; $display("[TB] FAIL basic_request: req=%0b addr=%0d len=%0d required 1,100,4", rd_request, rd_address, rd_burst_length); end
        serve_burst(4, 2, seen, got, stable);
        checks++;
        if (!seen || got != 100 || !stable)
            begin failures++; $display("[TB] FAIL basic_handshake: seen=%0b addr=%0d stable=%0b required 1,100,1", seen, got, stable); end
        pulse_line();
        checks++;
        if (rd_request !== 1'b1 || rd_address !== 23'd104 || row_valid !== 1'b1)
            begin failures++; $display("[TB] FAIL basic_next_request: req=%0b addr=%0d valid=%0b required 1,104,1", rd_request, rd_address, row_valid); end
        for (int c = 0; c < COLUMNS; c++) begin
            col_index = 2'(c); tick();
            checks++;
            if (charattr !== word_of(100, c))
                begin failures++; $display("[TB] FAIL basic_charattr col %0d: got %h required %h", c, charattr, word_of(100, c)); end
        end
    endtask

    // Whole frame against the model: scanline p = scroll + n gives row p/CH and
    // char_row p%CH; row k comes from the k-th page-wrapped fetch address.
    task automatic test_frame(input int b, input int f, input logic s);
        int ea [ROWS+1];
        int rows_shown, lines, p, row, crow, col, got, nxt;
        logic seen, stable;
        rows_shown = s ? ROWS + 1 : ROWS;
        ea[0] = f;
        for (int k = 1; k <= ROWS; k++) begin
            nxt = ea[k-1] + COLUMNS;
            ea[k] = (nxt >= b + PAGE) ? b : nxt;
        end
        pulse_frame(b, f, s);
        checks++;
        if (rd_request !== 1'b1 || int'(rd_address) != ea[0] || row_valid !== 1'b0 ||
            char_row !== s || text_row !== 2'd0)
            begin failures++; $display("[TB] FAIL frame_start: req=%0b addr=%0d valid=%0b crow=%0d trow=%0d required 1,%0d,0,%0d,0",
                     rd_request, rd_address, row_valid, char_row, text_row, ea[0], s); end
        serve_burst(4, $urandom_range(0, 3), seen, got, stable);
        checks++;
        if (!seen || got != ea[0] || !stable)
            begin failures++; $display("[TB] FAIL fetch_row0: seen=%0b addr=%0d stable=%0b required 1,%0d,1", seen, got, stable, ea[0]); end
        lines = (CH - int'(s)) + (rows_shown - 1) * CH;
        for (int n = 0; n <= lines; n++) begin
            p = int'(s) + n; row = p / CH; crow = p % CH;
            pulse_line();
            if (row < rows_shown) begin
                checks++;
                if (row_valid !== 1'b1 || int'(text_row) != row || int'(char_row) != crow)
                    begin failures++; $display("[TB] FAIL line %0d position: valid=%0b trow=%0d crow=%0d required 1,%0d,%0d",
                             n, row_valid, text_row, char_row, row, crow); end
                if (crow == 0 || n == 0) begin
                    col = $urandom_range(0, COLUMNS - 1);
                    col_index = 2'(col); tick();
                    checks++;
                    if (charattr !== word_of(ea[row], col))
                        begin failures++; $display("[TB] FAIL row %0d charattr col %0d: got %h required %h",
                                 row, col, charattr, word_of(ea[row], col)); end
                    if (row + 1 < rows_shown) begin
                        serve_burst(4, $urandom_range(0, 3), seen, got, stable);
                        checks++;
                        if (!seen || got != ea[row+1] || !stable)
                            begin failures++; $display("[TB] FAIL fetch_row%0d: seen=%0b addr=%0d stable=%0b required 1,%0d,1",
                                     row + 1, seen, got, stable, ea[row+1]); end
                    end else begin
                        checks++;
                        if (rd_request !== 1'b0)
                            begin failures++; $display("[TB] FAIL extra_fetch row %0d: req=%0b required 0", row, rd_request); end
                    end
                end
            end else begin
                checks++;
                if (row_valid !== 1'b0 || rd_request !== 1'b0)
                    begin failures++; $display("[TB] FAIL frame_end: valid=%0b req=%0b required 0,0", row_valid, rd_request); end
            end
        end
        checks++;
        if (underrun !== 1'b0)
            begin failures++; $display("[TB] FAIL frame_underrun: got %0b required 0", underrun); end
    endtask

    task automatic test_wrap();
        do_reset();
        test_frame(100, 108, 1'b0);
    endtask

    task automatic test_scroll();
        do_reset();
        test_frame(100, 100, 1'b1);
    endtask

    task automatic test_random_frames();
        int b;
        do_reset();
        for (int it = 0; it < 4; it++) begin
            b = $urandom_range(0, 100000);
            test_frame(b, b + COLUMNS * $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_simultaneous();
        logic seen, stable; int got, c;
        do_reset();
        pulse_frame(100, 100, 1'b0);
        serve_burst(4, 1, seen, got, stable);
        pulse_line();
        first_row = 23'd108; scroll = 1'b1;
        frame_start = 1'b1; line_start = 1'b1; tick();
        frame_start = 1'b0; line_start = 1'b0;
        checks++;
        if (row_valid !== 1'b0 || char_row !== 1'b1 || text_row !== 2'd0 ||
            rd_request !== 1'b1 || rd_address !== 23'd108 || underrun !== 1'b0)
            begin failures++; $display("[TB] FAIL simultaneous: valid=%0b crow=%0d trow=%0d req=%0b addr=%0d under=%0b required 0,1,0,1,108,0",
                     row_valid, char_row, text_row, rd_request, rd_address, underrun); end
        serve_burst(4, 2, seen, got, stable);
        pulse_line();
        checks++;
        if (row_valid !== 1'b1 || char_row !== 1'b1 || text_row !== 2'd0 ||
            rd_request !== 1'b1 || rd_address !== 23'd100)
            begin failures++; $display("[TB] FAIL after_simultaneous: valid=%0b crow=%0d trow=%0d req=%0b addr=%0d required 1,1,0,1,100",
                     row_valid, char_row, text_row, rd_request, rd_address); end
        c = $urandom_range(0, COLUMNS - 1);
        col_index = 2'(c); tick();
        checks++;
        if (charattr !== word_of(108, c))
            begin failures++; $display("[TB] FAIL simultaneous_charattr: got %h required %h", charattr, word_of(108, c)); end
    endtask

    task automatic test_underrun();
        logic seen, stable; int got;
        do_reset();
        pulse_frame(100, 100, 1'b0);
        serve_burst(4, 1, seen, got, stable);
        pulse_line();
        serve_burst(2, 1, seen, got, stable);
        checks++;
        if (!seen || got != 104 || rd_request !== 1'b0)
            begin failures++; $display("[TB] FAIL partial_burst: seen=%0b addr=%0d req=%0b required 1,104,0", seen, got, rd_request); end
        pulse_line();
        checks++;
        if (underrun !== 1'b0 || char_row !== 1'b1)
            begin failures++; $display("[TB] FAIL no_swap_no_underrun: under=%0b crow=%0d required 0,1", underrun, char_row); end
        pulse_line();
        checks++;
        if (underrun !== 1'b1 || rd_request !== 1'b1 || rd_address !== 23'd108 || text_row !== 2'd1)
            begin failures++; $display("[TB] FAIL underrun_swap: under=%0b req=%0b addr=%0d trow=%0d required 1,1,108,1",
                     underrun, rd_request, rd_address, text_row); end
        for (int c = 0; c < 2; c++) begin
            col_index = 2'(c); tick();
            checks++;
            if (charattr !== word_of(104, c))
                begin failures++; $display("[TB] FAIL partial_charattr col %0d: got %h required %h", c, charattr, word_of(104, c)); end
        end
        pulse_frame(100, 100, 1'b0);
        checks++;
        if (underrun !== 1'b1 || rd_request !== 1'b1 || rd_address !== 23'd100 || row_valid !== 1'b0)
            begin failures++; $display("[TB] FAIL underrun_sticky: under=%0b req=%0b addr=%0d valid=%0b required 1,1,100,0",
                     underrun, rd_request, rd_address, row_valid); end
    endtask

    task automatic test_reset_mid_burst();
        logic seen, stable; int got;
        logic [31:0] expv [4];
        do_reset();
        pulse_frame(200, 200, 1'b0);
        serve_burst(4, 1, seen, got, stable);
        pulse_frame(200, 204, 1'b0);
        serve_burst(2, 1, seen, got, stable);
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if (rd_request !== 1'b0 || row_valid !== 1'b0 || underrun !== 1'b0 ||
            rd_address !== '0 || charattr !== '0)
            begin failures++; $display("[TB] FAIL reset_mid_burst: req=%0b valid=%0b under=%0b addr=%0d ca=%h required 0,0,0,0,0",
                     rd_request, row_valid, underrun, rd_address, charattr); end
        for (int i = 0; i < 4; i++) begin
            rd_available = 1'b1; rd_data = ~word_of(204, i + 2); tick();
            rd_available = 1'b0;
        end
        tick();
        checks++;
        if (rd_request !== 1'b0)
            begin failures++; $display("[TB] FAIL idle_after_reset: req=%0b required 0", rd_request); end
        pulse_frame(200, 204, 1'b0);
        pulse_line();
        expv[0] = word_of(204, 0); expv[1] = word_of(204, 1);
        expv[2] = word_of(200, 2); expv[3] = word_of(200, 3);
        for (int c = 0; c < COLUMNS; c++) begin
            col_index = 2'(c); tick();
            checks++;
            if (charattr !== expv[c])
                begin failures++; $display("[TB] FAIL stale_buffer col %0d: got %h required %h", c, charattr, expv[c]); end
        end
    endtask

    initial begin
        salt = $urandom;
        reset = 1'b1; frame_start = 1'b0; line_start = 1'b0;
        base_address = '0; first_row = '0; scroll = '0;
        rd_ack = 1'b0; rd_available = 1'b0; rd_data = '0; col_index = '0;
        test_reset();
        test_basic_fetch();
        test_wrap();
        test_scroll();
        test_random_frames();
        test_simultaneous();
        test_underrun();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_row_fetcher.md
TEXT_ROW_FETCHER -- requirements
Module: text_row_fetcher

Interface
REQ-001 SHALL have parameter COLUMNS, default 80: character cells per text row, and SDRAM words per burst.
REQ-002 SHALL have parameter ROWS, default 51: text rows per frame.
REQ-003 SHALL have parameter CHAR_HEIGHT, default 20: scanlines per text row, minimum 2.
REQ-004 SHALL have parameters ADDR_WIDTH, default 23, and DATA_WIDTH, default 32: SDRAM address width and charattr word width.
REQ-005 SHALL have parameter PAGE_SIZE, default COLUMNS*ROWS: words per text page, used for wrap-around.
REQ-006 SHALL have port clk, input, 1 bit: clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port frame_start, input, 1 bit: one-cycle pulse one scanline before the first visible line.
REQ-009 SHALL have port line_start, input, 1 bit: one-cycle pulse at the start of every scanline.
REQ-010 SHALL have ports base_address and first_row, input, ADDR_WIDTH bits each: page base address and address of the top displayed row.
REQ-011 SHALL have port scroll, input, clog2(CHAR_HEIGHT) bits: smooth vertical scroll offset in scanlines.
REQ-012 SHALL have ports rd_request (output, 1 bit), rd_address (output, ADDR_WIDTH bits), rd_burst_length (output, 9 bits), rd_ack (input, 1 bit), rd_available (input, 1 bit) and rd_data (input, DATA_WIDTH bits): SDRAM burst read interface.
REQ-013 SHALL have ports col_index (input, clog2(COLUMNS) bits) and charattr (output, DATA_WIDTH bits): display-side random read.
REQ-014 SHALL have ports char_row (output, clog2(CHAR_HEIGHT) bits), text_row (output, clog2(ROWS+1) bits) and row_valid (output, 1 bit): current scanline within the row, current row, and display-active flag.
REQ-015 SHALL have port underrun, output, 1 bit: sticky flag meaning a burst was incomplete at a buffer swap.

Function
REQ-016 SHALL hold two COLUMNS-deep buffers in ping-pong: one is the display buffer and the other is the fill buffer.
REQ-017 SHALL, on frame_start, latch base_address and scroll, load fetch address first_row, set text_row to 0, set char_row to the latched scroll value, clear row_valid, and start a fetch into buffer 0.
REQ-018 SHALL, on the first line_start after frame_start, swap buffers, set row_valid to 1, and start fetching the next row.
REQ-019 SHALL, on each later line_start: if char_row equals CHAR_HEIGHT-1, set char_row to 0, increment text_row, swap buffers and start the next fetch; otherwise increment char_row.
REQ-020 SHALL, when text_row would exceed ROWS (ROWS+1 rows shown when scroll is nonzero, ROWS otherwise), clear row_valid and start no further fetches until the next frame_start.
REQ-021 SHALL advance the fetch address after each fetch start: next = addr+COLUMNS; if next is at or beyond base+PAGE_SIZE, use base instead; arithmetic is ADDR_WIDTH bits.
REQ-022 SHALL implement the fetch FSM IDLE->REQUEST->RECEIVE->IDLE.
REQ-023 SHALL, in REQUEST, hold rd_request at 1 with rd_address and rd_burst_length=COLUMNS stable until a cycle with rd_ack=1; rd_request SHALL drop the following cycle.
REQ-024 SHALL, in RECEIVE, write each rd_available word to fill-buffer index 0,1,2,…; after COLUMNS words, return to IDLE.
REQ-025 SHALL ignore rd_available in IDLE or REQUEST, and SHALL ignore any word beyond COLUMNS.
REQ-026 SHALL, if a swap occurs while the FSM is not IDLE: set underrun, abort the burst, drop rd_request, and restart REQUEST at the new address; unwritten entries keep stale data.
REQ-027 SHALL clear underrun only on reset.
REQ-028 SHALL give charattr one-cycle latency from col_index; a col_index of COLUMNS or more SHALL return 0.
REQ-029 SHALL give frame_start priority when frame_start and line_start occur in the same cycle.
REQ-030 SHALL treat frame_start during an active fetch as an abort that sets no underrun.

Reset
REQ-031 SHALL, on reset, set rd_request, row_valid, underrun, text_row, char_row and charattr to 0, rd_address to 0, rd_burst_length to COLUMNS, the FSM to IDLE, and buffer 0 as the fill buffer.
REQ-032 SHALL abort a burst immediately on reset mid-burst; buffer contents are not cleared.

Verification
(All scenarios use COLUMNS=4, ROWS=3, CHAR_HEIGHT=2, PAGE_SIZE=12.)
REQ-033 Bench SHALL cover: base=100, first_row=100, scroll=0, frame_start, rd_ack after 2 cycles, 4 words A0..A3 -> rd_address=100, burst 4; after the first line_start, charattr at col 0..3 reads A0..A3 and a request issues at 104.
REQ-034 Bench SHALL cover: first_row=108, base=100 -> fetch addresses 108, 100, 104; row_valid falls after the 3rd row's last line.
REQ-035 Bench SHALL cover: only 2 of 4 words delivered before the row swap -> underrun=1, rd_request reasserts the next cycle at the new address, and underrun stays 1 through the next frame_start.
REQ-036 Bench SHALL cover: scroll=1 -> char_row is 1 on the first visible line, 4 rows are fetched, and text_row reaches 3.
REQ-037 Bench SHALL cover: reset asserted mid-RECEIVE -> next cycle rd_request=0, FSM idle, and later rd_available words are ignored.
REQ-038 Bench SHALL cover: frame_start and line_start in the same cycle -> frame_start behaviour only, with char_row=scroll and row_valid=0.
